// File: rtl/fetch_queue_if.sv
// Fetch front-end bundle: decode-side handshake, imem request/response, redirect.
// master is the fetch unit; slave is whatever surrounds it (core or bench).
interface fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            enable;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic            out_ready;

  modport master (
    input  enable, redirect_valid, redirect_pc, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, out_pc, out_instr
  );

  modport slave (
    output enable, redirect_valid, redirect_pc, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end: PC generator, 1-cycle imem request path and a
// DEPTH-entry instruction queue drained by decode, flushed by branch redirects.
module fetch_queue_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_queue_if.master bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc_reg;
  logic            started_reg;
  logic            inflight_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW-1:0]   wr_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];

  logic            pop;
  logic            push;
  logic            issue;
  logic [CW:0]     occupancy;
  logic [DEPTH-1:0] wr_sel;
  logic            unused_addr_bits;

  assign pop  = (count_reg != '0) & bus.out_ready;
  assign push = inflight_reg & ~bus.redirect_valid;

  // Entries already held plus the one still in flight, minus the one leaving now.
  assign occupancy = {1'b0, count_reg} + (CW+1)'(inflight_reg) - (CW+1)'(pop);
  assign issue     = started_reg & bus.enable & ~bus.redirect_valid &
                     (occupancy < (CW+1)'(DEPTH));

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc_reg;
  assign bus.out_valid = (count_reg != '0);
  assign bus.out_pc    = pc_mem[rd_ptr_reg];
  assign bus.out_instr = instr_mem[rd_ptr_reg];

  assign unused_addr_bits = &{1'b0, bus.redirect_pc[1:0]};

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_wr_sel
      assign wr_sel[gi] = push && (wr_ptr_reg == AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_reg <= RESET_PC;
      started_reg  <= 1'b0;
      inflight_reg <= 1'b0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      started_reg <= 1'b1;
      if (bus.redirect_valid) begin
        fetch_pc_reg <= {bus.redirect_pc[XLEN-1:2], 2'b00};
        inflight_reg <= 1'b0;
        rd_ptr_reg   <= '0;
        wr_ptr_reg   <= '0;
        count_reg    <= '0;
      end else begin
        inflight_reg <= issue;
        if (issue) fetch_pc_reg <= fetch_pc_reg + XLEN'(4);
        if (push)  wr_ptr_reg   <= wr_ptr_reg + AW'(1);
        if (pop)   rd_ptr_reg   <= rd_ptr_reg + AW'(1);
        case ({push, pop})
          2'b10:   count_reg <= count_reg + CW'(1);
          2'b01:   count_reg <= count_reg - CW'(1);
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  // The returning word belongs to the address issued last cycle, which is
  // fetch_pc - 4 because any redirect since then would have cancelled the push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) begin
          pc_mem[i]    <= fetch_pc_reg - XLEN'(4);
          instr_mem[i] <= bus.imem_rdata;
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: streaming, back-pressure, redirects,
// PC wrap-around and asynchronous mid-cycle reset.
module tb_fetch_queue_unit;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fetch_queue_if #(.XLEN(32)) q ();
  fetch_queue_if #(.XLEN(32)) w ();

  fetch_queue_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(q.master)
  );
  fetch_queue_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst_n(rst_n), .bus(w.master)
  );

  // Synchronous instruction memories: word[i] = 0x1000_0000 + i.
  always @(posedge clk) if (q.imem_req) q.imem_rdata <= 32'h1000_0000 + {2'b00, q.imem_addr[31:2]};
  always @(posedge clk) if (w.imem_req) w.imem_rdata <= 32'h1000_0000 + {2'b00, w.imem_addr[31:2]};

  assign w.enable         = 1'b1;
  assign w.redirect_valid = 1'b0;
  assign w.redirect_pc    = 32'h0;
  assign w.out_ready      = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    q.enable         = 1'b1;
    q.redirect_valid = 1'b0;
    q.redirect_pc    = 32'h0;
    q.out_ready      = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    chk("rst_req",   32'(q.imem_req),  32'h0);
    chk("rst_valid", 32'(q.out_valid), 32'h0);
    chk("rst_addr",  q.imem_addr,      32'h0);
    chk("rst_pc",    q.out_pc,         32'h0);
    chk("rst_instr", q.out_instr,      32'h0);
    chk("rst_waddr", w.imem_addr,      32'hFFFF_FFF8);

    // Streaming from reset with decode always ready.
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("c1_req",    32'(q.imem_req),  32'h1);
    chk("c1_addr",   q.imem_addr,      32'h0);
    tick();
    chk("c2_valid",  32'(q.out_valid), 32'h0);
    tick();
    chk("c3_valid",  32'(q.out_valid), 32'h1);
    chk("c3_pc",     q.out_pc,         32'h0);
    chk("c3_instr",  q.out_instr,      32'h1000_0000);
    chk("wrap_pc0",  w.out_pc,         32'hFFFF_FFF8);
    chk("wrap_in0",  w.out_instr,      32'h4FFF_FFFE);
    tick();
    chk("c4_pc",     q.out_pc,         32'h4);
    chk("c4_instr",  q.out_instr,      32'h1000_0001);
    chk("wrap_pc1",  w.out_pc,         32'hFFFF_FFFC);
    chk("wrap_in1",  w.out_instr,      32'h4FFF_FFFF);
    tick();
    chk("c5_pc",     q.out_pc,         32'h8);
    chk("wrap_pc2",  w.out_pc,         32'h0);
    chk("wrap_in2",  w.out_instr,      32'h1000_0000);
    tick();
    chk("c6_pc",     q.out_pc,         32'hC);
    chk("c6_valid",  32'(q.out_valid), 32'h1);

    // Back-pressure: queue fills to DEPTH, then drains without gaps.
    q.out_ready = 1'b0;
    do_reset();
    repeat (12) tick();
    chk("full_req",   32'(q.imem_req),  32'h0);
    chk("full_valid", 32'(q.out_valid), 32'h1);
    chk("full_pc",    q.out_pc,         32'h0);
    q.out_ready = 1'b1;
    #1;
    chk("drain_pc0",  q.out_pc,         32'h0);
    tick();
    chk("drain_pc1",  q.out_pc,         32'h4);
    tick();
    chk("drain_pc2",  q.out_pc,         32'h8);
    tick();
    chk("drain_pc3",  q.out_pc,         32'hC);
    tick();
    chk("drain_pc4",  q.out_pc,         32'h10);
    chk("drain_in4",  q.out_instr,      32'h1000_0004);

    // Redirect with three entries queued and one in flight.
    q.out_ready = 1'b0;
    do_reset();
    repeat (5) tick();
    chk("pre_rd_req",   32'(q.imem_req),  32'h0);
    chk("pre_rd_valid", 32'(q.out_valid), 32'h1);
    q.redirect_valid = 1'b1;
    q.redirect_pc    = 32'h100;
    tick();
    q.redirect_valid = 1'b0;
    #1;
    chk("rd1_valid", 32'(q.out_valid), 32'h0);
    chk("rd1_req",   32'(q.imem_req),  32'h1);
    chk("rd1_addr",  q.imem_addr,      32'h100);
    tick();
    chk("rd2_valid", 32'(q.out_valid), 32'h0);
    tick();
    chk("rd3_valid", 32'(q.out_valid), 32'h1);
    chk("rd3_pc",    q.out_pc,         32'h100);
    chk("rd3_instr", q.out_instr,      32'h1000_0040);
    q.out_ready = 1'b1;
    tick();
    chk("rd4_pc",    q.out_pc,         32'h104);

    // Unaligned redirect target coinciding with a pop.
    q.redirect_valid = 1'b1;
    q.redirect_pc    = 32'h203;
    #1;
    chk("rp_head",   q.out_pc,         32'h104);
    tick();
    q.redirect_valid = 1'b0;
    #1;
    chk("rp1_addr",  q.imem_addr,      32'h200);
    chk("rp1_req",   32'(q.imem_req),  32'h1);
    chk("rp1_valid", 32'(q.out_valid), 32'h0);
    tick();
    tick();
    chk("rp3_pc",    q.out_pc,         32'h200);
    chk("rp3_instr", q.out_instr,      32'h1000_0080);

    // Asynchronous reset mid-cycle with a nearly full queue and a fetch in flight.
    q.out_ready = 1'b0;
    do_reset();
    repeat (5) tick();
    chk("ar_pre_valid", 32'(q.out_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(q.out_valid), 32'h0);
    chk("ar_req",   32'(q.imem_req),  32'h0);
    chk("ar_addr",  q.imem_addr,      32'h0);
    chk("ar_pc",    q.out_pc,         32'h0);
    chk("ar_instr", q.out_instr,      32'h0);
    tick();
    chk("ar_hold_req", 32'(q.imem_req), 32'h0);
    @(negedge clk);
    q.out_ready = 1'b1;
    rst_n       = 1'b1;
    tick();
    chk("ar_c1_req",   32'(q.imem_req),  32'h1);
    chk("ar_c1_addr",  q.imem_addr,      32'h0);
    tick();
    chk("ar_c2_valid", 32'(q.out_valid), 32'h0);
    tick();
    chk("ar_c3_valid", 32'(q.out_valid), 32'h1);
    chk("ar_c3_pc",    q.out_pc,         32'h0);
    chk("ar_c3_instr", q.out_instr,      32'h1000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
